// File: rtl/joint_histogram_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : jh_pkg                                                          |
// | Purpose  : Shared types and sizing helpers for the joint-histogram         |
// |            scheduler (state enum, default widths, address/bin derivation). |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package jh_pkg;

  localparam int IDX_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    COUNT = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4
  } state_t;

  // Bin address is the concatenation {pix_a, pix_b}.
  function automatic int addr_w(input int idx_w);
    return 2 * idx_w;
  endfunction

  function automatic int nbins(input int idx_w);
    return 1 << (2 * idx_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/joint_histogram_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: joint_histogram_scheduler_if                                    |
// | Purpose  : Pixel-pair input stream, bin RAM port and bin output stream.    |
// |            slave  = scheduler side, master = surrounding environment.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface joint_histogram_scheduler_if
  import jh_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int ADDR_W = addr_w(IDX_W);

  logic              pix_valid;
  logic              pix_ready;
  logic [IDX_W-1:0]  pix_a;
  logic [IDX_W-1:0]  pix_b;
  logic              pix_last;

  logic [ADDR_W-1:0] ram_raddr;
  logic [CNT_W-1:0]  ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CNT_W-1:0]  ram_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_bin;
  logic [CNT_W-1:0]  out_count;
  logic              out_last;

  modport slave (
    input  pix_valid, pix_a, pix_b, pix_last, ram_rdata, out_ready,
    output pix_ready, ram_raddr, ram_we, ram_waddr, ram_wdata,
    output out_valid, out_bin, out_count, out_last
  );

  modport master (
    output pix_valid, pix_a, pix_b, pix_last, ram_rdata, out_ready,
    input  pix_ready, ram_raddr, ram_we, ram_waddr, ram_wdata,
    input  out_valid, out_bin, out_count, out_last
  );

endinterface
`default_nettype wire

// File: rtl/joint_histogram_scheduler_rmw.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jh_rmw_pipe                                                     |
// | Purpose  : Read-modify-write increment stage used while counting. Read is  |
// |            issued by the caller in the accept cycle; this stage writes     |
// |            base+1 one cycle later with a one-deep forward of the previous  |
// |            write. Macro JH_SATURATE_EN: saturate at max instead of wrap.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module jh_rmw_pipe #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  rdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [CNT_W-1:0]  wdata
);

  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic              fwd_vld;
  logic [ADDR_W-1:0] fwd_addr;
  logic [CNT_W-1:0]  fwd_data;
  logic [CNT_W-1:0]  base;
  logic [CNT_W-1:0]  sum;

  // Hold the accepted pair's address until its read data returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      pend <= acc;
      if (acc) pend_addr <= addr;
    end
  end

  // Keep the write issued this cycle: a read in the same cycle sees stale RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      fwd_vld  <= pend;
      fwd_addr <= pend_addr;
      fwd_data <= sum;
    end
  end

  // Pick the freshest base value and increment it.
  always_comb begin
    base = (fwd_vld && (fwd_addr == pend_addr)) ? fwd_data : rdata;
`ifdef JH_SATURATE_EN
    sum = (base == '1) ? base : base + CNT_W'(1);
`else
    sum = base + CNT_W'(1);
`endif
  end

  // Write port stays quiet (all zero) when no increment is pending.
  always_comb begin
    we    = pend;
    waddr = pend ? pend_addr : '0;
    wdata = pend ? sum : '0;
  end

endmodule
`default_nettype wire

// File: rtl/joint_histogram_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : joint_histogram_scheduler                                       |
// | Purpose  : Clears the bin RAM, counts pixel pairs by read-modify-write,    |
// |            then streams every bin out through a 2-entry buffer.            |
// |            Macro JH_SATURATE_EN (in jh_rmw_pipe): saturating counts.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module joint_histogram_scheduler
  import jh_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  joint_histogram_scheduler_if.slave  bus
);

  localparam int ADDR_W = addr_w(IDX_W);
  localparam int NBINS  = nbins(IDX_W);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NBINS - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W:0]   rd_addr;
  logic              rd_pend;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic [ADDR_W-1:0] bin_q;
  logic [2:0]        inflight;
  logic              acc;
  logic              pop;
  logic              issue;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [CNT_W-1:0]  pipe_wdata;

  assign acc = bus.pix_valid && (state == COUNT);
  assign pop = (occ != 2'd0) && bus.out_ready;

  // Output stream is the buffer head; bin index is a running counter.
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_count = cnt0;
  assign bus.out_bin   = bin_q;
  assign bus.out_last  = (occ != 2'd0) && (bin_q == LAST_BIN);

  jh_rmw_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rmw (
    .clk   (clk),
    .rst   (rst),
    .acc   (acc),
    .addr  ({bus.pix_a, bus.pix_b}),
    .rdata (bus.ram_rdata),
    .we    (pipe_we),
    .waddr (pipe_waddr),
    .wdata (pipe_wdata)
  );

  // Next-state, RAM port muxing and read-issue decision.
  always_comb begin
    state_nx      = state;
    bus.pix_ready = (state == COUNT);
    busy          = (state != IDLE);
    bus.ram_raddr = '0;
    bus.ram_we    = pipe_we;
    bus.ram_waddr = pipe_waddr;
    bus.ram_wdata = pipe_wdata;
    // Reads in flight after this cycle's pop; never more than the buffer holds.
    inflight      = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    issue         = (state == READ) && !rd_addr[ADDR_W] && (inflight < 3'd2);
    case (state)
      IDLE:  if (start) state_nx = CLEAR;
      CLEAR: begin
        bus.ram_we    = 1'b1;
        bus.ram_waddr = clr_cnt;
        bus.ram_wdata = '0;
        if (clr_cnt == LAST_BIN) state_nx = COUNT;
      end
      COUNT: begin
        bus.ram_raddr = {bus.pix_a, bus.pix_b};
        if (acc && bus.pix_last) state_nx = DRAIN;
      end
      DRAIN: state_nx = READ;
      READ: begin
        bus.ram_raddr = rd_addr[ADDR_W-1:0];
        if (pop && bus.out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == READ) && (state_nx == IDLE);
    end
  end

  // Clear address counter; wraps back to zero after the last bin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    else clr_cnt <= '0;
  end

  // Readout: issue reads in order and absorb 1-cycle latency in a 2-deep buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
      rd_pend <= 1'b0;
      occ     <= 2'd0;
      cnt0    <= '0;
      cnt1    <= '0;
      bin_q   <= '0;
    end else if (state != READ) begin
      rd_addr <= '0;
      rd_pend <= 1'b0;
      occ     <= 2'd0;
      bin_q   <= '0;
    end else begin
      rd_addr <= rd_addr + (ADDR_W + 1)'(issue);
      rd_pend <= issue;
      bin_q   <= bin_q + ADDR_W'(pop);
      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) cnt0 <= bus.ram_rdata;
          else cnt1 <= bus.ram_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          cnt0 <= cnt1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            cnt0 <= bus.ram_rdata;
          end else begin
            cnt0 <= cnt1;
            cnt1 <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_joint_histogram_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_joint_histogram_scheduler                                    |
// | Purpose  : Self-checking bench for joint_histogram_scheduler with a        |
// |            behavioural bin RAM and a histogram reference model.            |
// |            Honors JH_SATURATE_EN in the reference model.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_joint_histogram_scheduler;

  localparam int IDX_W = 2;
  localparam int CNT_W = 3;
  localparam int NB    = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;

  joint_histogram_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  joint_histogram_scheduler #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural simple dual-port RAM, 1-cycle read, read-before-write.
  logic [CNT_W-1:0] mem [NB];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int qa[$];
  int qb[$];
  int expc[NB];
  int got[NB];
  int n_out, order_err, stall_err, last_err, done_err, first_cyc, last_cyc;

  // Reference histogram built straight from the list of pairs.
  task automatic build_model();
    for (int b = 0; b < NB; b++) expc[b] = 0;
    foreach (qa[i]) begin
      int ad;
      ad = qa[i] * 4 + qb[i];
`ifdef JH_SATURATE_EN
      if (expc[ad] < CMAX) expc[ad] = expc[ad] + 1;
`else
      expc[ad] = (expc[ad] + 1) % (CMAX + 1);
`endif
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pairs(input int gap_pct, input bit with_last);
    foreach (qa[i]) begin
      int w;
      if ($urandom_range(99) < gap_pct) begin
        bus.pix_valid = 1'b0;
        bus.pix_a     = IDX_W'($urandom);
        bus.pix_b     = IDX_W'($urandom);
        @(negedge clk);
      end
      bus.pix_valid = 1'b1;
      bus.pix_a     = IDX_W'(qa[i]);
      bus.pix_b     = IDX_W'(qb[i]);
      bus.pix_last  = with_last && (i == qa.size() - 1);
      w = 0;
      while (!bus.pix_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) begin
        checks++;
        errors++;
        $display("FAIL pix_accept timeout pair %0d: pix_ready=%b, required 1", i, bus.pix_ready);
      end
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
  endtask

  // Drain the readout stream; mode 0 ready high, 1 pattern 1,0,0,1, 2 random with noise.
  task automatic collect(input int mode);
    int cyc = 0;
    bit r;
    bit prev_stall = 1'b0;
    int pb = 0;
    int pc = 0;
    n_out = 0; order_err = 0; stall_err = 0; last_err = 0; done_err = 0;
    first_cyc = -1; last_cyc = -1;
    for (int b = 0; b < NB; b++) got[b] = -1;
    while (n_out < NB && cyc < 300) begin
      case (mode)
        0: r = 1'b1;
        1: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom);
      endcase
      bus.out_ready = r;
      if (mode == 2) begin
        bus.pix_valid = 1'b1;
        bus.pix_a     = IDX_W'($urandom);
        bus.pix_b     = IDX_W'($urandom);
        start         = (cyc == 4);
      end
      if (prev_stall && (!bus.out_valid || int'(bus.out_bin) != pb || int'(bus.out_count) != pc))
        stall_err++;
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (bus.out_last !== (bus.out_bin == 4'(NB - 1))) last_err++;
        if (r) begin
          if (int'(bus.out_bin) != n_out) order_err++;
          got[bus.out_bin] = int'(bus.out_count);
          n_out++;
          last_cyc = cyc;
        end
      end
      prev_stall = bus.out_valid && !r;
      pb = int'(bus.out_bin);
      pc = int'(bus.out_count);
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.pix_valid = 1'b0;
    start         = 1'b0;
    if (done !== 1'b1) done_err++;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) done_err++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_a = '0; bus.pix_b = '0; bus.pix_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pix_ready, bus.ram_we, bus.out_valid, bus.out_last, busy, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 000000",
               {bus.pix_ready, bus.ram_we, bus.out_valid, bus.out_last, busy, done});
    end
    checks++;
    if ({bus.ram_raddr, bus.ram_waddr, bus.out_bin} !== 12'b0) begin
      errors++;
      $display("FAIL reset_addrs got %h required 000", {bus.ram_raddr, bus.ram_waddr, bus.out_bin});
    end
    checks++;
    if ({bus.ram_wdata, bus.out_count} !== 6'b0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {bus.ram_wdata, bus.out_count});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    qa = '{1, 3, 1};
    qb = '{2, 0, 2};
    build_model();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_waddr !== 4'd0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_first busy=%b we=%b waddr=%0d ready=%b required 1 1 0 0",
               busy, bus.ram_we, bus.ram_waddr, bus.pix_ready);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b1 || bus.ram_waddr !== 4'd15 || bus.ram_wdata !== 3'd0 || bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_last we=%b waddr=%0d wdata=%0d ready=%b required 1 15 0 0",
               bus.ram_we, bus.ram_waddr, bus.ram_wdata, bus.pix_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.pix_ready !== 1'b1 || bus.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL count_entry ready=%b we=%b required 1 0", bus.pix_ready, bus.ram_we);
    end
    send_pairs(0, 1'b1);
    checks++;
    if (bus.pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_ready got %b required 0", bus.pix_ready);
    end
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (got[b] !== expc[b]) begin
        errors++;
        $display("FAIL basic_bin%0d got %0d required %0d", b, got[b], expc[b]);
      end
    end
    checks++;
    if (n_out !== NB || order_err !== 0 || last_err !== 0 || done_err !== 0) begin
      errors++;
      $display("FAIL basic_stream outs=%0d order=%0d last=%0d done=%0d required 16 0 0 0",
               n_out, order_err, last_err, done_err);
    end
    checks++;
    if (first_cyc > 3 || last_cyc - first_cyc !== NB - 1) begin
      errors++;
      $display("FAIL basic_latency first=%0d span=%0d required <=3 and 15", first_cyc, last_cyc - first_cyc);
    end
  endtask

  task automatic test_forward();
    qa = '{2, 2, 2, 2, 2};
    qb = '{2, 2, 2, 2, 2};
    build_model();
    pulse_start();
    send_pairs(0, 1'b1);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (got[b] !== expc[b]) begin
        errors++;
        $display("FAIL forward_bin%0d got %0d required %0d", b, got[b], expc[b]);
      end
    end
  endtask

  task automatic test_alternating();
    qa = '{0, 0, 1, 0};
    qb = '{1, 1, 0, 1};
    build_model();
    pulse_start();
    send_pairs(0, 1'b1);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (got[b] !== expc[b]) begin
        errors++;
        $display("FAIL alt_bin%0d got %0d required %0d", b, got[b], expc[b]);
      end
    end
  endtask

  task automatic test_stall();
    qa = {};
    qb = {};
    for (int i = 0; i < 12; i++) begin
      qa.push_back($urandom_range(3));
      qb.push_back($urandom_range(3));
    end
    build_model();
    pulse_start();
    send_pairs(30, 1'b1);
    collect(1);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (got[b] !== expc[b]) begin
        errors++;
        $display("FAIL stall_bin%0d got %0d required %0d", b, got[b], expc[b]);
      end
    end
    checks++;
    if (n_out !== NB || order_err !== 0 || stall_err !== 0 || last_err !== 0 || done_err !== 0) begin
      errors++;
      $display("FAIL stall_stream outs=%0d order=%0d stall=%0d last=%0d done=%0d required 16 0 0 0 0",
               n_out, order_err, stall_err, last_err, done_err);
    end
  endtask

  task automatic test_overflow();
    int req;
    qa = {};
    qb = {};
    for (int i = 0; i < CMAX + 2; i++) begin
      qa.push_back(0);
      qb.push_back(0);
    end
`ifdef JH_SATURATE_EN
    req = CMAX;
`else
    req = 1;
`endif
    pulse_start();
    send_pairs(20, 1'b1);
    collect(0);
    checks++;
    if (got[0] !== req) begin
      errors++;
      $display("FAIL overflow_bin0 got %0d required %0d", got[0], req);
    end
  endtask

  task automatic test_reset_midframe();
    qa = '{3, 3, 1, 2};
    qb = '{3, 3, 1, 0};
    pulse_start();
    send_pairs(0, 1'b0);
    bus.pix_valid = 1'b1;
    bus.pix_a     = 2'd3;
    bus.pix_b     = 2'd3;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.pix_ready, bus.ram_we, bus.out_valid, busy, done} !== 5'b0 ||
        {bus.ram_raddr, bus.ram_waddr, bus.ram_wdata} !== 11'b0) begin
      errors++;
      $display("FAIL midreset_outputs flags=%b raddr=%0d waddr=%0d wdata=%0d required all 0",
               {bus.pix_ready, bus.ram_we, bus.out_valid, busy, done},
               bus.ram_raddr, bus.ram_waddr, bus.ram_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    qa = '{0, 1, 2};
    qb = '{1, 1, 2};
    build_model();
    pulse_start();
    send_pairs(10, 1'b1);
    collect(0);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (got[b] !== expc[b]) begin
        errors++;
        $display("FAIL midreset_bin%0d got %0d required %0d", b, got[b], expc[b]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(5, 30);
      qa = {};
      qb = {};
      for (int i = 0; i < n; i++) begin
        qa.push_back($urandom_range(3));
        qb.push_back($urandom_range(3));
      end
      build_model();
      pulse_start();
      bus.pix_valid = 1'b1;
      repeat (5) begin
        bus.pix_a = IDX_W'($urandom);
        bus.pix_b = IDX_W'($urandom);
        @(negedge clk);
      end
      send_pairs(40, 1'b1);
      collect(2);
      for (int b = 0; b < NB; b++) begin
        checks++;
        if (got[b] !== expc[b]) begin
          errors++;
          $display("FAIL random%0d_bin%0d got %0d required %0d", f, b, got[b], expc[b]);
        end
      end
      checks++;
      if (n_out !== NB || order_err !== 0 || stall_err !== 0 || last_err !== 0 || done_err !== 0) begin
        errors++;
        $display("FAIL random%0d_stream outs=%0d order=%0d stall=%0d last=%0d done=%0d required 16 0 0 0 0",
                 f, n_out, order_err, stall_err, last_err, done_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forward();
    test_alternating();
    test_stall();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
